// File: rtl/dmg_timer_pkg.sv
// Shared definitions for the DMG timer/divider block: register map, TAC tap lookup and FSM
// states.
package dmg_timer_pkg;

    localparam logic [1:0] RegDiv  = 2'd0;
    localparam logic [1:0] RegTima = 2'd1;
    localparam logic [1:0] RegTma  = 2'd2;
    localparam logic [1:0] RegTac  = 2'd3;

    // Unused TAC bits read back as ones
    localparam logic [7:0] TacReadMask = 8'hF8;

    typedef enum logic [1:0] {
        StIdle,
        StOvf,
        StReload
    } timer_state_e;

    function automatic logic [3:0] tac_tap_idx(input logic [1:0] clk_sel);
        logic [3:0] idx;
        case (clk_sel)
            2'b00:   idx = 4'd9;
            2'b01:   idx = 4'd3;
            2'b10:   idx = 4'd5;
            default: idx = 4'd7;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/dmg_timer_edge.sv
// Divider tap mux and falling-edge detector. Emits a one-clk tick when the gated tap falls;
// gating with en means disabling the source while the tap is high also produces a tick.
module dmg_timer_edge #(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned TAP_W = $clog2(DIV_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    input  logic [TAP_W-1:0] tap_idx,
    input  logic             en,
    output logic             tick
);

    logic level;
    logic tick_prev;

    assign level = div[tap_idx] & en;

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_prev <= 1'b0;
        end else begin
            tick_prev <= level;
        end
    end

    assign tick = tick_prev & ~level;

endmodule

// File: rtl/dmg_timer.sv
// DMG timer/divider register block (FF04-FF07): system divider, TIMA counter with delayed TMA
// reload and timer interrupt request.
module dmg_timer
    import dmg_timer_pkg::*;
#(
    parameter int unsigned      DIV_W     = 16,
    parameter int unsigned      OVF_DELAY = 4,
    parameter logic [DIV_W-1:0] DIV_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic [1:0]       addr,
    input  logic             wr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata,
    output logic [DIV_W-1:0] div_q,
    output logic             irq_timer
);

    localparam int unsigned     TapW    = $clog2(DIV_W);
    localparam int unsigned     CntW    = (OVF_DELAY > 1) ? $clog2(OVF_DELAY) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(OVF_DELAY - 1);

    logic [DIV_W-1:0] div;
    logic [7:0]       tima;
    logic [7:0]       tma;
    logic [2:0]       tac;
    timer_state_e     state;
    logic [CntW-1:0]  cnt;
    logic             irq;

    logic            wr_div;
    logic            wr_tima;
    logic            wr_tma;
    logic            wr_tac;
    logic [TapW-1:0] tap_idx;
    logic            tick;

    assign wr_div  = sel & wr & (addr == RegDiv);
    assign wr_tima = sel & wr & (addr == RegTima);
    assign wr_tma  = sel & wr & (addr == RegTma);
    assign wr_tac  = sel & wr & (addr == RegTac);

    assign tap_idx = TapW'(tac_tap_idx(tac[1:0]));

    dmg_timer_edge #(
        .DIV_W (DIV_W),
        .TAP_W (TapW)
    ) u_edge (
        .clk     (clk),
        .reset   (reset),
        .div     (div),
        .tap_idx (tap_idx),
        .en      (tac[2]),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            div <= DIV_RESET;
        end else if (wr_div) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tma <= 8'h00;
            tac <= 3'b000;
        end else begin
            if (wr_tma) tma <= wdata;
            if (wr_tac) tac <= wdata[2:0];
        end
    end

    // TIMA and the overflow/reload sequencer; irq is high for the RELOAD clk only
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= StIdle;
            cnt   <= '0;
            tima  <= 8'h00;
            irq   <= 1'b0;
        end else begin
            irq <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (wr_tima) begin
                        tima <= wdata;
                    end else if (tick) begin
                        if (tima == 8'hFF) begin
                            tima  <= 8'h00;
                            cnt   <= '0;
                            state <= StOvf;
                        end else begin
                            tima <= tima + 8'd1;
                        end
                    end
                end
                StOvf: begin
                    if (wr_tima) begin
                        tima  <= wdata;
                        state <= StIdle;
                    end else begin
                        if (tick) tima <= tima + 8'd1;
                        if (cnt == CntLast) begin
                            state <= StReload;
                            irq   <= 1'b1;
                        end else begin
                            cnt <= cnt + CntW'(1);
                        end
                    end
                end
                StReload: begin
                    // A TMA write landing in this clk is forwarded into TIMA
                    tima  <= wr_tma ? wdata : tma;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (sel) begin
            unique case (addr)
                RegDiv:  rdata = div[DIV_W-1 -: 8];
                RegTima: rdata = tima;
                RegTma:  rdata = tma;
                RegTac:  rdata = TacReadMask | {5'b00000, tac};
                default: rdata = 8'h00;
            endcase
        end
    end

    assign div_q     = div;
    assign irq_timer = irq;

endmodule

// File: tb/tb_dmg_timer.sv
// Directed bench for dmg_timer: register-access vector table plus hand-built overflow, reload,
// DIV-write and TAC-write sequences.
module tb_dmg_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [1:0]  addr;
    logic        wr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [15:0] div_q;
    logic        irq_timer;

    int checks   = 0;
    int failures = 0;
    int irq_cnt  = 0;

    typedef struct {
        logic       do_wr;
        logic       wsel;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic       rsel;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    dmg_timer #(
        .DIV_W     (16),
        .OVF_DELAY (4),
        .DIV_RESET (16'h0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel),
        .addr      (addr),
        .wr        (wr),
        .wdata     (wdata),
        .rdata     (rdata),
        .div_q     (div_q),
        .irq_timer (irq_timer)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (irq_timer === 1'b1) irq_cnt++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        sel   = 1'b1;
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        step();
        wr  = 1'b0;
        sel = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
        sel  = 1'b1;
        addr = a;
        #1;
        check(name, rdata, exp);
        sel = 1'b0;
    endtask

    // Program TMA, then TIMA=0xFE with div[3] selected; returns in the first OVF clk
    task automatic setup_ovf(input logic [7:0] tma_v);
        wr_reg(2'd3, 8'h00);
        wr_reg(2'd2, tma_v);
        wr_reg(2'd0, 8'h00);
        wr_reg(2'd1, 8'hFE);
        wr_reg(2'd3, 8'h05);
        steps(30);
        check_reg("ovf_pre_wrap_ff", 2'd1, 8'hFF);
        step();
        check_reg("ovf_wrap_00", 2'd1, 8'h00);
        irq_cnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        vecs[0] = '{1'b1, 1'b1, 2'd2, 8'h5A, 1'b1, 8'h5A};
        vecs[1] = '{1'b1, 1'b0, 2'd2, 8'h11, 1'b1, 8'h5A};
        vecs[2] = '{1'b0, 1'b1, 2'd2, 8'h00, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 2'd1, 8'h42, 1'b1, 8'h42};
        vecs[4] = '{1'b1, 1'b0, 2'd1, 8'h99, 1'b1, 8'h42};
        vecs[5] = '{1'b1, 1'b1, 2'd3, 8'h03, 1'b1, 8'hFB};
        vecs[6] = '{1'b1, 1'b1, 2'd3, 8'h00, 1'b1, 8'hF8};
        vecs[7] = '{1'b1, 1'b1, 2'd1, 8'hC3, 1'b1, 8'hC3};
        vecs[8] = '{1'b1, 1'b1, 2'd0, 8'hAB, 1'b1, 8'h00};
        vecs[9] = '{1'b0, 1'b1, 2'd1, 8'h00, 1'b0, 8'h00};

        reset = 1'b1;
        sel   = 1'b0;
        wr    = 1'b0;
        addr  = 2'd0;
        wdata = 8'h00;
        steps(2);
        check("reset_div", div_q, 16'h0000);
        check("reset_irq", irq_timer, 1'b0);
        check_reg("reset_tima", 2'd1, 8'h00);
        check_reg("reset_tma", 2'd2, 8'h00);
        check_reg("reset_tac", 2'd3, 8'hF8);
        reset   = 1'b0;
        irq_cnt = 0;

        // Free-running divider
        steps(256);
        check("div_256", div_q, 16'h0100);
        check_reg("div_read_01", 2'd0, 8'h01);
        step();
        check_reg("idle_tima", 2'd1, 8'h00);
        check("idle_irq_cnt", irq_cnt, 0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_wr) begin
                sel   = vecs[i].wsel;
                wr    = 1'b1;
                addr  = vecs[i].addr;
                wdata = vecs[i].wdata;
                step();
                wr  = 1'b0;
                sel = 1'b0;
            end else begin
                step();
            end
            sel  = vecs[i].rsel;
            addr = vecs[i].addr;
            #1;
            check($sformatf("vec%0d", i), rdata, vecs[i].exp);
            sel = 1'b0;
        end

        // Overflow with delayed reload from TMA
        setup_ovf(8'hA0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_reg($sformatf("ovf_hold_%0d", i), 2'd1, 8'h00);
        end
        step();
        check("reload_irq_high", irq_timer, 1'b1);
        step();
        check_reg("reload_tima_a0", 2'd1, 8'hA0);
        steps(4);
        check("reload_irq_once", irq_cnt, 1);

        // TIMA write in the second OVF clk cancels the reload
        setup_ovf(8'hA0);
        step();
        wr_reg(2'd1, 8'h33);
        steps(4);
        check_reg("cancel_tima_33", 2'd1, 8'h33);
        check("cancel_no_irq", irq_cnt, 0);

        // TMA write in the RELOAD clk is forwarded
        setup_ovf(8'hA0);
        steps(4);
        check("tma_fwd_irq_high", irq_timer, 1'b1);
        wr_reg(2'd2, 8'h55);
        check_reg("tma_fwd_tima_55", 2'd1, 8'h55);
        steps(2);
        check("tma_fwd_irq_once", irq_cnt, 1);

        // TIMA write in the RELOAD clk is ignored
        setup_ovf(8'hA0);
        steps(4);
        wr_reg(2'd1, 8'h77);
        check_reg("tima_wr_ignored_a0", 2'd1, 8'hA0);
        steps(2);
        check("tima_wr_ignored_irq", irq_cnt, 1);

        // DIV write while div[9]=1 gives exactly one increment
        wr_reg(2'd3, 8'h00);
        wr_reg(2'd1, 8'h10);
        wr_reg(2'd0, 8'h00);
        wr_reg(2'd3, 8'h04);
        n = 0;
        while (div_q[9] !== 1'b1 && n < 600) begin
            step();
            n++;
        end
        check("div9_reached", div_q[9], 1'b1);
        check_reg("div9_tima_before", 2'd1, 8'h10);
        wr_reg(2'd0, 8'h00);
        check("div_wr_zero", div_q, 16'h0000);
        step();
        check_reg("div_wr_tima_inc", 2'd1, 8'h11);
        steps(20);
        check_reg("div_wr_tima_once", 2'd1, 8'h11);

        // DIV write coinciding with the natural div[9] fall
        n = 0;
        while (div_q !== 16'h03FF && n < 1100) begin
            step();
            n++;
        end
        check("div_3ff_reached", div_q, 16'h03FF);
        wr_reg(2'd0, 8'h00);
        steps(5);
        check_reg("coincide_one_inc", 2'd1, 8'h12);

        // Disabling TAC while div[3]=1 produces one spurious increment
        wr_reg(2'd3, 8'h00);
        wr_reg(2'd1, 8'h20);
        wr_reg(2'd0, 8'h00);
        wr_reg(2'd3, 8'h05);
        n = 0;
        while (div_q[3] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("div3_reached", div_q[3], 1'b1);
        check_reg("tac_off_before", 2'd1, 8'h20);
        wr_reg(2'd3, 8'h00);
        steps(3);
        check_reg("tac_off_spurious", 2'd1, 8'h21);
        steps(20);
        check_reg("tac_off_stays", 2'd1, 8'h21);

        // Reset during OVF aborts the reload
        setup_ovf(8'hA0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reg("ovf_reset_tima", 2'd1, 8'h00);
        steps(8);
        check_reg("ovf_reset_tima_later", 2'd1, 8'h00);
        check("ovf_reset_no_irq", irq_cnt, 0);
        check_reg("ovf_reset_tma", 2'd2, 8'h00);
        check_reg("ovf_reset_tac", 2'd3, 8'hF8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmg_timer.md
Name: dmg_timer

Overview:
- CPU-side register responder for the timer/divider window FF04–FF07: DIV, TIMA, TMA, TAC.
- Owns the 16-bit system divider counter.
- Increments TIMA on falling edges of a TAC-selected divider tap, reloads it from TMA after overflow, and raises the timer interrupt request.
- Sits between the CPU bus decode (ff04_ff07 select, cpu_wr, address bits) and the interrupt controller. Exports divider taps for the APU/serial blocks.

Parameters:
- DIV_W, 16, divider width; DIV register reads bits [DIV_W-1:DIV_W-8].
- OVF_DELAY, 4, clocks from TIMA wrap (0xFF→0x00) to TMA reload and IRQ.
- DIV_RESET, 16'h0000, divider value after reset.

Ports:
- clk  in  1  4.194304 MHz T-cycle clock (atal_4mhz domain)
- reset  in  1  synchronous, active-high reset
- sel  in  1  bus access targets FF04–FF07 (ff04_ff07)
- addr  in  2  register select: 0=DIV, 1=TIMA, 2=TMA, 3=TAC
- wr  in  1  write strobe, one clk wide, qualified by sel
- wdata  in  8  write data
- rdata  out  8  read data, combinational from addr; 0x00 when sel=0
- div_q  out  DIV_W  divider counter, for APU frame sequencer and serial clock
- irq_timer  out  1  one-clk pulse on TMA reload

Behaviour:
- Reset state:
  - div=DIV_RESET, tima=0, tma=0, tac=0, state=IDLE, irq_timer=0, edge register=0.
  - rdata follows the reset registers.
- Divider:
  - div increments by 1 every clk and wraps modulo 2^DIV_W.
  - Any write to addr 0 forces div=0 on that edge. wdata is ignored.
- Register reads:
  - DIV = div[15:8].
  - TAC reads {5'b11111, tac[2:0]}.
  - TIMA and TMA read raw.
- Tap select:
  - tac[1:0]: 00→div[9], 01→div[3], 10→div[5], 11→div[7].
  - tick_src = tap & tac[2].
- Increment:
  - Registered tick_prev. TIMA increments when tick_prev=1 and tick_src=0.
  - The edge source includes DIV reset and TAC writes. Both can produce a spurious increment, and this is required behaviour.
- FSM states: IDLE, OVF (counter 0..OVF_DELAY-1), RELOAD.
  - IDLE: an increment with tima=0xFF sets tima=0x00 and moves to OVF, cnt=0.
  - OVF: tima reads 0x00 and cnt advances.
    - A CPU write to TIMA during OVF loads wdata, cancels the reload, and returns to IDLE with no IRQ.
    - A falling edge during OVF increments tima normally.
    - When cnt=OVF_DELAY-1, next state is RELOAD.
  - RELOAD (one clk): tima←tma, irq_timer=1, then IDLE.
    - A CPU TIMA write in the RELOAD clk is ignored.
    - A TMA write in the RELOAD clk updates tma, and the new value is what loads into TIMA.
- Simultaneous events:
  - CPU TIMA write and increment edge in IDLE: the write wins.
  - DIV write and tap falling edge in the same clk: one increment only.
- Reset mid-OVF/RELOAD: returns to IDLE with no IRQ.
- wr with sel=0 is ignored.

Decomposition:
- Shared package dmg_timer_pkg holds:
  - register index constants (DIV/TIMA/TMA/TAC)
  - TAC tap-index lookup
  - FSM state enum
  - TAC unused-bit read mask 0xF8
- Sub-module dmg_timer_edge: the tap mux plus falling-edge detector, which outputs a tick pulse. It is reused by the APU frame sequencer on div[12].

Test Plan:
- Reset, then run 256 clk with no writes → DIV reads 0x01; TIMA=0x00; irq_timer never high.
- TAC=0x05 (enable, div[3]), TIMA=0xFE, TMA=0xA0; wait 32 clk → TIMA wraps to 0x00, reads 0x00 for 4 clk, then 0xA0; irq_timer high exactly 1 clk.
- Overflow, then write TIMA=0x33 in the 2nd OVF clk → TIMA=0x33, no reload, no irq_timer.
- Overflow, then write TMA=0x55 in the RELOAD clk → TIMA=0x55 and irq fires. Repeat with a TIMA=0x77 write in RELOAD → TIMA=0xA0, not 0x77.
- TAC=0x04 (div[9]), run until div[9]=1, then write DIV → TIMA increments by exactly 1; div_q=0 the next clk.
- TAC=0x05 with div[3]=1, then write TAC=0x00 → one spurious TIMA increment. Assert reset during OVF → IDLE, TIMA=0, no irq_timer.
